// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: windowed RGB565 pixel pipeline with read-latency alignment and test patterns.
// Optional window border (all-ones edge pixels): define VGA_PIXEL_PIPE_BORDER_EN.
module vga_pixel_pipe #(
  parameter int ADDR_W = 11,
  parameter int PIC_X0 = 0,
  parameter int PIC_Y0 = 0,
  parameter int PIC_W  = 1024,
  parameter int PIC_H  = 720,
  parameter int RD_LAT = 1,
  parameter int R_W    = 5,
  parameter int G_W    = 6,
  parameter int B_W    = 5
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Ready_Sig,
  input  logic [ADDR_W-1:0] Column_Addr_Sig,
  input  logic [ADDR_W-1:0] Row_Addr_Sig,
  input  logic [1:0]        Mode_Sig,
  input  logic              Mode_Load,
  input  logic [15:0]       Solid_Color,
  output logic              pix_req,
  input  logic [15:0]       display_data,
  input  logic              data_valid,
  input  logic              underrun_clr,
  output logic [R_W-1:0]    Red_Sig,
  output logic [G_W-1:0]    Green_Sig,
  output logic [B_W-1:0]    Blue_Sig,
  output logic              is_pic,
  output logic              frame_start,
  output logic [7:0]        frame_cnt,
  output logic              underrun
);

  localparam int L = RD_LAT;
  localparam logic [31:0] X0 = 32'(PIC_X0);
  localparam logic [31:0] X1 = 32'(PIC_X0 + PIC_W);
  localparam logic [31:0] Y0 = 32'(PIC_Y0);
  localparam logic [31:0] Y1 = 32'(PIC_Y0 + PIC_H);
  localparam logic [15:0] BARS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  logic [31:0]       col;
  logic [31:0]       row;
  logic              in_win;
  logic              bound;
  logic [ADDR_W-1:0] lx;
  logic [ADDR_W-1:0] ly;
  logic [1:0]        pend;
  logic [1:0]        act;
  logic [1:0]        mode0;
  logic              run;
  logic              run0;

  assign col    = 32'(Column_Addr_Sig);
  assign row    = 32'(Row_Addr_Sig);
  assign in_win = Ready_Sig && col >= X0 && col < X1
                  && row >= Y0 && row < Y1;
  assign bound  = Ready_Sig && col == X0 && row == Y0;
  assign lx     = ADDR_W'(col - X0);
  assign ly     = ADDR_W'(row - Y0);

  // The first pixel of a frame already belongs to the new mode.
  assign mode0   = bound ? pend : act;
  assign run0    = run | bound;
  assign pix_req = in_win && mode0 == 2'd0;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pend <= 2'd0;
      act  <= 2'd0;
      run  <= 1'b0;
    end else begin
      if (Mode_Load) pend <= Mode_Sig;
      if (bound) begin
        act <= pend;
        run <= 1'b1;
      end
    end
  end

  logic [L:1]             q_rdy;
  logic [L:1]             q_win;
  logic [L:1]             q_sof;
  logic [L:1]             q_run;
  logic [L:1][1:0]        q_mode;
  logic [L:1][ADDR_W-1:0] q_lx;
  logic [L:1][ADDR_W-1:0] q_ly;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      q_rdy  <= '0;
      q_win  <= '0;
      q_sof  <= '0;
      q_run  <= '0;
      q_mode <= '0;
      q_lx   <= '0;
      q_ly   <= '0;
    end else begin
      q_rdy[1]  <= Ready_Sig;
      q_win[1]  <= in_win;
      q_sof[1]  <= bound;
      q_run[1]  <= run0;
      q_mode[1] <= mode0;
      q_lx[1]   <= lx;
      q_ly[1]   <= ly;
      for (int i = 2; i <= L; i++) begin
        q_rdy[i]  <= q_rdy[i-1];
        q_win[i]  <= q_win[i-1];
        q_sof[i]  <= q_sof[i-1];
        q_run[i]  <= q_run[i-1];
        q_mode[i] <= q_mode[i-1];
        q_lx[i]   <= q_lx[i-1];
        q_ly[i]   <= q_ly[i-1];
      end
    end
  end

  logic              hit;
  logic              under_hit;
  logic [1:0]        a_mode;
  logic [ADDR_W-1:0] a_lx;
  logic [ADDR_W-1:0] a_ly;
  logic [2:0]        bar;
  logic [15:0]       pix;

  assign a_mode    = q_mode[L];
  assign a_lx      = q_lx[L];
  assign a_ly      = q_ly[L];
  assign hit       = q_run[L] && q_win[L] && q_rdy[L];
  assign under_hit = hit && a_mode == 2'd0 && !data_valid;

  // bar = (lx*8)/PIC_W via constant thresholds ceil(k*PIC_W/8)
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (32'(a_lx) >= 32'((k * PIC_W + 7) / 8)) bar = bar + 3'd1;
    end
  end

  always_comb begin
    pix = 16'h0000;
    if (hit) begin
      unique case (a_mode)
        2'd0:    pix = data_valid ? display_data : 16'h0000;
        2'd1:    pix = BARS[bar];
        2'd2:    pix = (a_lx[4] ^ a_ly[4]) ? 16'hFFFF : 16'h0000;
        default: pix = Solid_Color;
      endcase
`ifdef VGA_PIXEL_PIPE_BORDER_EN
      if (a_lx == '0 || 32'(a_lx) == 32'(PIC_W - 1)
          || a_ly == '0 || 32'(a_ly) == 32'(PIC_H - 1))
        pix = 16'hFFFF;
`endif
    end
  end

  // MSB-first copy, wrapping around the source field to widen it.
  logic [R_W-1:0] r_n;
  logic [G_W-1:0] g_n;
  logic [B_W-1:0] b_n;

  for (genvar i = 0; i < R_W; i++) begin : g_r
    assign r_n[R_W-1-i] = pix[15-(i%5)];
  end
  for (genvar i = 0; i < G_W; i++) begin : g_g
    assign g_n[G_W-1-i] = pix[10-(i%6)];
  end
  for (genvar i = 0; i < B_W; i++) begin : g_b
    assign b_n[B_W-1-i] = pix[4-(i%5)];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Red_Sig     <= '0;
      Green_Sig   <= '0;
      Blue_Sig    <= '0;
      is_pic      <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
      underrun    <= 1'b0;
    end else begin
      Red_Sig     <= r_n;
      Green_Sig   <= g_n;
      Blue_Sig    <= b_n;
      is_pic      <= hit;
      frame_start <= q_sof[L];
      frame_cnt   <= frame_cnt + {7'd0, q_sof[L]};
      underrun    <= under_hit | (underrun & ~underrun_clr);
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb_vga_pixel_pipe: directed frame-scan bench for vga_pixel_pipe.
// 36x34 window at (3,2) in a 44x38 raster, RD_LAT=2, 8-bit channels.
module tb_vga_pixel_pipe;

  localparam int X0 = 3;
  localparam int Y0 = 2;
  localparam int W  = 36;
  localparam int H  = 34;
  localparam int HT = 44;
  localparam int VT = 38;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        Ready_Sig;
  logic [10:0] Column_Addr_Sig;
  logic [10:0] Row_Addr_Sig;
  logic [1:0]  Mode_Sig;
  logic        Mode_Load;
  logic [15:0] Solid_Color;
  logic        pix_req;
  logic [15:0] display_data;
  logic        data_valid;
  logic        underrun_clr;
  logic [7:0]  Red_Sig;
  logic [7:0]  Green_Sig;
  logic [7:0]  Blue_Sig;
  logic        is_pic;
  logic        frame_start;
  logic [7:0]  frame_cnt;
  logic        underrun;

  always #5 CLK = ~CLK;

  vga_pixel_pipe #(
    .ADDR_W(11), .PIC_X0(X0), .PIC_Y0(Y0), .PIC_W(W), .PIC_H(H),
    .RD_LAT(2), .R_W(8), .G_W(8), .B_W(8)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .Ready_Sig(Ready_Sig),
    .Column_Addr_Sig(Column_Addr_Sig), .Row_Addr_Sig(Row_Addr_Sig),
    .Mode_Sig(Mode_Sig), .Mode_Load(Mode_Load),
    .Solid_Color(Solid_Color), .pix_req(pix_req),
    .display_data(display_data), .data_valid(data_valid),
    .underrun_clr(underrun_clr), .Red_Sig(Red_Sig),
    .Green_Sig(Green_Sig), .Blue_Sig(Blue_Sig), .is_pic(is_pic),
    .frame_start(frame_start), .frame_cnt(frame_cnt),
    .underrun(underrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [23:0] o_rgb [VT][HT];
  logic        o_pic [VT][HT];
  logic        o_fs  [VT][HT];
  logic        o_und [VT][HT];

  int ml_r = -1, ml_c = 0;
  logic [1:0] ml_v = 2'd0;
  int d1r = -1, d1c = 0, d2r = -1, d2c = 0, c1r = -1, c1c = 0;
  int rst_r = -1, rst_c = 0;
  int pr_out, pr_in;

  logic [15:0] dq [3] = '{default: 16'h0};
  logic        vq [3] = '{default: 1'b1};
  logic        cq [3] = '{default: 1'b0};
  int hc [3] = '{default: 0};
  int hr [3] = '{default: 0};

  function automatic logic [23:0] to888(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  function automatic logic [23:0] bdr(input int x, input int y,
                                      input logic [23:0] e);
`ifdef VGA_PIXEL_PIPE_BORDER_EN
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 24'hFFFFFF;
`endif
    return e;
  endfunction

  function automatic logic [15:0] bar565(input int i);
    case (i)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic cyc(input int c, input int r, input logic rdy);
    logic inw;
    @(posedge CLK);
    #1;
    inw = rdy && c >= X0 && c < X0 + W && r >= Y0 && r < Y0 + H;
    Column_Addr_Sig = 11'(c);
    Row_Addr_Sig    = 11'(r);
    Ready_Sig       = rdy;
    Mode_Load       = (r == ml_r && c == ml_c);
    Mode_Sig        = ml_v;
    dq[2] = dq[1]; dq[1] = dq[0];
    vq[2] = vq[1]; vq[1] = vq[0];
    cq[2] = cq[1]; cq[1] = cq[0];
    dq[0] = inw ? 16'(c - X0) : 16'h0;
    vq[0] = !(inw && ((r == d1r && c == d1c) || (r == d2r && c == d2c)));
    cq[0] = (r == d2r && c == d2c) || (r == c1r && c == c1c);
    display_data = dq[2];
    data_valid   = vq[2];
    underrun_clr = cq[2];
    if (r == rst_r && c == rst_c) begin
      #1 RSTn = 1'b0;
      #1;
      check("rst_rgb", {Red_Sig, Green_Sig, Blue_Sig}, 0);
      check("rst_pic", is_pic, 0);
      check("rst_fs", frame_start, 0);
      check("rst_cnt", frame_cnt, 0);
      check("rst_und", underrun, 0);
      #1 RSTn = 1'b1;
    end
    @(negedge CLK);
    if (pix_req && !inw) pr_out++;
    if (pix_req) pr_in++;
    o_rgb[hr[2]][hc[2]] = {Red_Sig, Green_Sig, Blue_Sig};
    o_pic[hr[2]][hc[2]] = is_pic;
    o_fs[hr[2]][hc[2]]  = frame_start;
    o_und[hr[2]][hc[2]] = underrun;
    hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = c;
    hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = r;
  endtask

  task automatic frame();
    pr_out = 0;
    pr_in  = 0;
    for (int r = 0; r < VT; r++)
      for (int c = 0; c < HT; c++)
        cyc(c, r, c < 42 && r < 37);
  endtask

  function automatic int fs_count();
    int n = 0;
    for (int r = 0; r < VT; r++)
      for (int c = 0; c < HT; c++)
        if (o_fs[r][c]) n++;
    return n;
  endfunction

  initial begin
    RSTn = 1'b0;
    Ready_Sig = 1'b0;
    Column_Addr_Sig = '0;
    Row_Addr_Sig = '0;
    Mode_Sig = 2'd0;
    Mode_Load = 1'b0;
    Solid_Color = 16'hF800;
    display_data = '0;
    data_valid = 1'b1;
    underrun_clr = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_rgb", {Red_Sig, Green_Sig, Blue_Sig}, 0);
    check("reset_pic", is_pic, 0);
    check("reset_fs", frame_start, 0);
    check("reset_cnt", frame_cnt, 0);
    check("reset_und", underrun, 0);
    RSTn = 1'b1;

    // Frame 1: picture ramp, bars requested mid-frame
    ml_r = Y0 + 10; ml_c = 10; ml_v = 2'd1;
    frame();
    for (int x = 0; x < W; x++)
      check("ramp", o_rgb[Y0+5][X0+x], bdr(x, 5, to888(16'(x))));
    check("ramp_after_load", o_rgb[Y0+20][X0+17], to888(16'd17));
    check("pic_last", o_pic[Y0+5][X0+W-1], 1);
    check("pic_past_end", o_pic[Y0+5][X0+W], 0);
    check("pic_before", o_pic[Y0+5][X0-1], 0);
    check("pic_row_after", o_pic[Y0+H][X0+4], 0);
    check("req_outside", pr_out, 0);
    check("req_count", pr_in, W * H);
    check("fs_count1", fs_count(), 1);
    check("fs_pos", o_fs[Y0][X0], 1);
    check("fcnt1", frame_cnt, 1);

    // Frame 2: colour bars, checkerboard requested mid-frame
    ml_r = Y0 + 20; ml_c = 5; ml_v = 2'd2;
    frame();
    for (int x = 0; x < W; x++)
      check("bar", o_rgb[Y0+7][X0+x],
            bdr(x, 7, to888(bar565((x * 8) / W))));
    check("bar_no_req", pr_in, 0);
    check("fs_count2", fs_count(), 1);
    check("fcnt2", frame_cnt, 2);

    // Frame 3: checkerboard; load on the boundary cycle applies next frame
    ml_r = Y0; ml_c = X0; ml_v = 2'd3;
    frame();
    for (int x = 0; x < W; x++) begin
      check("chk_a", o_rgb[Y0+3][X0+x],
            bdr(x, 3, ((x >> 4) & 1) != 0 ? 24'hFFFFFF : 24'h0));
      check("chk_b", o_rgb[Y0+20][X0+x],
            bdr(x, 20, (((x >> 4) ^ 1) & 1) != 0 ? 24'hFFFFFF : 24'h0));
    end

    // Frame 4: solid red, back to picture requested mid-frame
    ml_r = Y0 + 10; ml_c = 0; ml_v = 2'd0;
    frame();
    check("solid_a", o_rgb[Y0+10][X0+10], 24'hFF0000);
    check("solid_b", o_rgb[Y0+30][X0+20], 24'hFF0000);
    check("solid_und", underrun, 0);
    check("fcnt4", frame_cnt, 4);

    // Frame 5: picture with two missing pixels and clears
    ml_r = -1;
    d1r = Y0 + 4; d1c = X0 + 7;
    d2r = Y0 + 6; d2c = X0 + 9;
    c1r = Y0 + 8; c1c = X0;
    frame();
    check("und_before", o_und[Y0+4][X0+6], 0);
    check("und_set", o_und[Y0+4][X0+7], 1);
    check("und_pix", o_rgb[Y0+4][X0+7], 0);
    check("und_pic", o_pic[Y0+4][X0+7], 1);
    check("und_next", o_rgb[Y0+4][X0+8], to888(16'd8));
    check("und_set_wins", o_und[Y0+6][X0+9], 1);
    check("und_held", o_und[Y0+8][X0-1], 1);
    check("und_clr", o_und[Y0+8][X0], 0);
    check("fcnt5", frame_cnt, 5);
    d1r = -1; d2r = -1; c1r = -1;

    // Degenerate frames to wrap the counter
    for (int i = 0; i < 250; i++) begin
      cyc(X0, Y0, 1'b1);
      cyc(0, 0, 1'b0);
    end
    repeat (3) cyc(0, 0, 1'b0);
    check("fcnt255", frame_cnt, 255);
    cyc(X0, Y0, 1'b1);
    repeat (3) cyc(0, 0, 1'b0);
    check("fcnt_wrap", frame_cnt, 0);

    // Reset mid-line, remainder of the frame stays dark
    rst_r = Y0 + 10; rst_c = X0 + 15;
    frame();
    rst_r = -1;
    begin
      int nz = 0;
      for (int r = Y0 + 12; r < VT; r++)
        for (int c = 0; c < HT; c++)
          if (o_pic[r][c] || o_rgb[r][c] != 0) nz++;
      check("post_rst_dark", nz, 0);
    end
    check("post_rst_cnt", frame_cnt, 0);

    // Next frame resumes picture output
    frame();
    check("resume_a", o_rgb[Y0+9][X0+5], to888(16'd5));
    check("resume_b", o_rgb[Y0+9][X0+30], to888(16'd30));
    check("resume_pic", o_pic[Y0+9][X0+30], 1);
    check("resume_cnt", frame_cnt, 1);
    check("resume_und", underrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
